// File: rtl/det_pkg.sv
// Shared defaults and helpers for the detection event logger.
package det_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // Increment v, clamping at the all-ones value of a w-bit field (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/det_event_logger_fifo.sv
// Synchronous FIFO with registered read port, registered flags and
// simultaneous push/pop; pointers carry one extra wrap bit.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_nxt, rd_nxt, lvl_nxt;
  logic             do_push, do_pop;

  // A full FIFO still accepts a push when a pop frees the head slot this cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_nxt = wr_ptr;
    rd_nxt = rd_ptr;
    if (do_push) wr_nxt = wr_ptr + (AW+1)'(1);
    if (do_pop)  rd_nxt = rd_ptr + (AW+1)'(1);
    lvl_nxt = wr_nxt - rd_nxt;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      level    <= lvl_nxt;
      empty    <= (lvl_nxt == '0);
      full     <= (lvl_nxt == (AW+1)'(DEPTH));
      rd_valid <= do_pop;
      if (do_pop) rd_data <= mem[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: rtl/det_event_logger.sv
// Timestamps each accepted 1011 detection into a FIFO, counts detections
// (saturating) and keeps a sticky overflow flag for dropped entries.
module det_event_logger
  import det_pkg::*;
#(
  parameter int TS_W  = TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     det,
  input  logic                     rd_en,
  input  logic                     clr_ovf,
  output logic [TS_W-1:0]          rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         det_count,
  output logic                     overflow
);

  logic [TS_W-1:0] ts;
  logic            accept, pop_ok, drop;

  assign accept = det & en;
  assign pop_ok = rd_en & ~empty;
  // Dropped only when full and no pop makes room in the same cycle.
  assign drop   = accept & full & ~pop_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts        <= '0;
      det_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (en) ts <= ts + TS_W'(1);
      if (accept) det_count <= CNT_W'(sat_inc(32'(det_count), CNT_W));
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (accept),
    .pop      (rd_en),
    .din      (ts),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .level    (level)
  );

endmodule
